// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter arbiter: FSM state encoding, datapath
// operation codes, requester count and a small index-to-one-hot helper.
// No ports; imported by counter_arbiter and rr_select.
package counter_ctrl_pkg;

  // Number of requesters sharing the counter and the width of a winner index.
  localparam int NUM_REQ = 2;
  localparam int IDX_W   = 1;

  // Datapath operation encoding driven on op.
  localparam logic OP_INC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CHECK = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Converts a requester index into a one-hot requester vector.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Winner selection between the two requesters: the requester named by
// pointer wins if it is requesting, otherwise the other one does.
// Ports: req (request vector), pointer (preferred index) -> w (winner index),
//        valid (at least one request present). Purely combinational.
module rr_select
  import counter_ctrl_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [IDX_W-1:0]   w,
  output logic               valid
);

  // With two requesters the only alternative to the preferred one is its
  // complement, so the priority rotation collapses to a single mux.
  assign valid = |req;
  assign w     = req[pointer] ? pointer : ~pointer;

endmodule

// File: rtl/counter_arbiter.sv
// Arbitrating controller for a shared up/down counter datapath. Two
// requesters ask for increment/decrement; one transaction runs at a time
// through INIT -> IDLE -> CHECK -> (EXEC) -> DONE, refusing operations that
// would wrap (z/m status) and acknowledging each request with ack/err.
// Config macro: RR_PRIORITY_EN -- defined: round-robin tie-break with a
// pointer register; undefined: fixed priority (requester 0 wins ties).
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req[1:0]        per-requester request, held until ack
//   dir[1:0]        per-requester direction (1 = inc, 0 = dec)
//   clr             synchronous clear request for the counter
//   z, m            datapath status: count nonzero / count below max
//   op, c_ld, c_clr datapath operation, load strobe, clear strobe
//   gnt[1:0]        one-hot owner of the transaction in flight
//   ack[1:0], err   completion pulse and refusal flag
//   busy            high in every state except IDLE
// All outputs are registered alongside the state so they line up with it.
module counter_arbiter
  import counter_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] dir,
  input  logic               clr,
  input  logic               z,
  input  logic               m,
  output logic               op,
  output logic               c_ld,
  output logic               c_clr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [NUM_REQ-1:0] ack,
  output logic               err,
  output logic               busy
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_w;
  logic               r_dir;
  logic               r_blocked;

  logic               r_op;
  logic               r_c_ld;
  logic               r_c_clr;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_ack;
  logic               r_err;
  logic               r_busy;

  logic [IDX_W-1:0]   w_ptr;
  logic [IDX_W-1:0]   w_sel;
  logic               w_sel_vld;
  logic               w_allowed;

`ifdef RR_PRIORITY_EN
  logic [IDX_W-1:0]   r_ptr;
  assign w_ptr = r_ptr;
`else
  // Fixed priority: requester 0 is always preferred, no pointer state.
  assign w_ptr = '0;
`endif

  rr_select u_rr_select (
    .req     (req),
    .pointer (w_ptr),
    .w       (w_sel),
    .valid   (w_sel_vld)
  );

  // Status inputs are only consulted here, in CHECK, so a refused operation
  // never reaches the datapath and no wrap-around is ever commanded.
  assign w_allowed = (r_dir & m) | (~r_dir & z);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_w       <= '0;
      r_dir     <= 1'b0;
      r_blocked <= 1'b0;
`ifdef RR_PRIORITY_EN
      r_ptr     <= '0;
`endif
      r_op      <= OP_INC;
      r_c_ld    <= 1'b0;
      r_c_clr   <= 1'b1;
      r_gnt     <= '0;
      r_ack     <= '0;
      r_err     <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      // Strobes and the ack/err pulse are single-cycle unless re-asserted.
      r_op    <= OP_INC;
      r_c_ld  <= 1'b0;
      r_c_clr <= 1'b0;
      r_ack   <= '0;
      r_err   <= 1'b0;

      case (r_state)
        ST_INIT: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end

        ST_IDLE: begin
          // clr wins over a pending request; the request stays high and is
          // picked up once INIT has cleared the counter.
          if (clr) begin
            r_state <= ST_INIT;
            r_c_clr <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_sel_vld) begin
            r_state   <= ST_CHECK;
            r_w       <= w_sel;
            r_dir     <= dir[w_sel];
            r_blocked <= 1'b0;
            r_gnt     <= idx_to_onehot(w_sel);
            r_busy    <= 1'b1;
          end
        end

        ST_CHECK: begin
          if (w_allowed) begin
            r_state <= ST_EXEC;
            r_c_ld  <= 1'b1;
            r_op    <= r_dir ? OP_INC : OP_DEC;
          end else begin
            // Refused at a boundary: skip EXEC and report through err.
            r_state   <= ST_DONE;
            r_blocked <= 1'b1;
            r_ack     <= idx_to_onehot(r_w);
            r_err     <= 1'b1;
          end
        end

        ST_EXEC: begin
          r_state <= ST_DONE;
          r_ack   <= idx_to_onehot(r_w);
          r_err   <= r_blocked;
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
`ifdef RR_PRIORITY_EN
          // The requester just served drops to lowest priority.
          r_ptr   <= ~r_w;
`endif
        end

        default: begin
          r_state <= ST_INIT;
          r_c_clr <= 1'b1;
          r_gnt   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign op    = r_op;
  assign c_ld  = r_c_ld;
  assign c_clr = r_c_clr;
  assign gnt   = r_gnt;
  assign ack   = r_ack;
  assign err   = r_err;
  assign busy  = r_busy;

  // Structural invariants of the controller outputs.
  a_ld_clr_excl : assert property (@(posedge clk) disable iff (reset) !(c_ld && c_clr));
  a_op_with_ld  : assert property (@(posedge clk) disable iff (reset) op |-> c_ld);
  a_ack_onehot  : assert property (@(posedge clk) disable iff (reset) $onehot0(ack));
  a_gnt_onehot  : assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
  a_err_w_ack   : assert property (@(posedge clk) disable iff (reset) err |-> (|ack));

endmodule

// File: tb/tb_counter_arbiter.sv
module tb_counter_arbiter;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req   = 2'b00;
  logic [1:0] dir   = 2'b00;
  logic       clr   = 1'b0;
  logic       z     = 1'b0;
  logic       m     = 1'b0;
  logic       op, c_ld, c_clr, err, busy;
  logic [1:0] gnt, ack;

  int checks   = 0;
  int failures = 0;

  counter_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .dir   (dir),
    .clr   (clr),
    .z     (z),
    .m     (m),
    .op    (op),
    .c_ld  (c_ld),
    .c_clr (c_clr),
    .gnt   (gnt),
    .ack   (ack),
    .err   (err),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Output snapshot: {busy, gnt, ack, err, c_ld, c_clr, op}
  logic [8:0] obs;
  assign obs = {busy, gnt, ack, err, c_ld, c_clr, op};

  function automatic logic [8:0] pk(input logic b, input logic [1:0] g, input logic [1:0] a,
                                    input logic e, input logic ld, input logic cl, input logic o);
    return {b, g, a, e, ld, cl, o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = 2'b00; dir = 2'b00; clr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    logic [8:0] e;
    reset = 1'b1;
    tick();
    tick();
    e = pk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL reset_hold got=%b exp=%b", obs, e); end
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== e) begin failures++; $display("FAIL init_after_release got=%b exp=%b", obs, e); end
    tick();
    e = pk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL idle_after_init got=%b exp=%b", obs, e); end
  endtask

  task automatic test_inc();
    logic [8:0] e;
    req = 2'b01; dir = 2'b01; m = 1'b1; z = 1'b0;
    tick();
    e = pk(1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL inc_check got=%b exp=%b", obs, e); end
    tick();
    e = pk(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL inc_exec got=%b exp=%b", obs, e); end
    tick();
    e = pk(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL inc_done got=%b exp=%b", obs, e); end
    req = 2'b00;
    tick();
    e = pk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL inc_idle got=%b exp=%b", obs, e); end
  endtask

  task automatic test_dec_blocked();
    logic [8:0] e;
    req = 2'b10; dir = 2'b00; z = 1'b0; m = 1'b1;
    tick();
    e = pk(1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL decblk_check got=%b exp=%b", obs, e); end
    tick();
    e = pk(1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL decblk_done got=%b exp=%b", obs, e); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_dec();
    logic [8:0] e;
    req = 2'b10; dir = 2'b00; z = 1'b1; m = 1'b0;
    tick();
    tick();
    e = pk(1'b1, 2'b10, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL dec_exec got=%b exp=%b", obs, e); end
    tick();
    e = pk(1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL dec_done got=%b exp=%b", obs, e); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_inc_at_max();
    logic [8:0] e;
    req = 2'b01; dir = 2'b01; m = 1'b0; z = 1'b1;
    tick();
    tick();
    e = pk(1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL incmax_done got=%b exp=%b", obs, e); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_latch();
    logic [8:0] e;
    req = 2'b01; dir = 2'b01; m = 1'b1; z = 1'b0;
    tick();
    dir = 2'b10;
    tick();
    e = pk(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL latch_exec got=%b exp=%b", obs, e); end
    m = 1'b0;
    tick();
    e = pk(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL latch_done got=%b exp=%b", obs, e); end
    req = 2'b00; dir = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1:0] got [3];
    logic [1:0] exp [3];
    int n;
    logic [8:0] e;
`ifdef RR_PRIORITY_EN
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01;
`else
    exp[0] = 2'b01; exp[1] = 2'b01; exp[2] = 2'b01;
`endif
    apply_reset();
    n = 0;
    req = 2'b11; dir = 2'b11; m = 1'b1; z = 1'b1;
    for (int cyc = 0; cyc < 40 && n < 3; cyc++) begin
      tick();
      if (ack !== 2'b00) begin
        got[n] = ack;
        n++;
        if (n == 3) req = 2'b00;
      end
    end
    checks++;
    if (n != 3) begin failures++; $display("FAIL b2b_timeout acks_seen=%0d exp=3", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++; $display("FAIL b2b_ack%0d got=%b exp=%b", i, got[i], exp[i]);
      end
    end
    tick();
    e = pk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL b2b_idle got=%b exp=%b", obs, e); end
  endtask

  task automatic test_clr();
    logic [8:0] e;
    clr = 1'b1; req = 2'b01; dir = 2'b01; m = 1'b1;
    tick();
    e = pk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL clr_init got=%b exp=%b", obs, e); end
    clr = 1'b0;
    tick();
    e = pk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL clr_idle got=%b exp=%b", obs, e); end
    tick();
    tick();
    e = pk(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL clr_exec got=%b exp=%b", obs, e); end
    tick();
    e = pk(1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL clr_done got=%b exp=%b", obs, e); end
    req = 2'b00;
    tick();
  endtask

  task automatic test_reset_in_exec();
    logic [8:0] e;
    int stray;
    req = 2'b01; dir = 2'b01; m = 1'b1;
    tick();
    tick();
    e = pk(1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL rstexec_exec got=%b exp=%b", obs, e); end
    reset = 1'b1;
    #1;
    e = pk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL rstexec_async got=%b exp=%b", obs, e); end
    req = 2'b00;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== e) begin failures++; $display("FAIL rstexec_init got=%b exp=%b", obs, e); end
    tick();
    e = pk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin failures++; $display("FAIL rstexec_idle got=%b exp=%b", obs, e); end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack !== 2'b00) stray++;
    end
    checks++;
    if (stray != 0) begin failures++; $display("FAIL rstexec_no_ack stray_acks=%0d exp=0", stray); end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_dec_blocked();
    test_dec();
    test_inc_at_max();
    test_latch();
    test_clr();
    test_reset_in_exec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/counter_arbiter.md
COUNTER_ARBITER -- requirements
Module: counter_arbiter

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces INIT.
REQ-004 req  input  2  per-requester access request; bit i = requester i; held until ack[i].
REQ-005 dir  input  2  per-requester direction; 1 = increment, 0 = decrement; sampled with req.
REQ-006 clr  input  1  synchronous clear request for the shared counter.
REQ-007 z  input  1  datapath status; 1 = count nonzero (decrement allowed).
REQ-008 m  input  1  datapath status; 1 = count below max (increment allowed).
REQ-009 op  output  1  datapath operation; 0 = increment, 1 = decrement.
REQ-010 c_ld  output  1  datapath load strobe; one cycle per executed operation.
REQ-011 c_clr  output  1  datapath clear strobe.
REQ-012 gnt  output  2  one-hot grant; owner of the current transaction, 0 when idle.
REQ-013 ack  output  2  one-cycle completion pulse to the granted requester.
REQ-014 err  output  1  valid with ack; 1 = operation refused at a boundary, counter unchanged.
REQ-015 busy  output  1  1 in every state except IDLE.

Function
REQ-016 FSM states SHALL be INIT, IDLE, CHECK, EXEC and DONE.
REQ-017 INIT: c_clr=1 for exactly one cycle, then IDLE.
REQ-018 IDLE: clr=1 -> INIT, with clr taking priority over req; else any req bit set -> latch winner index w and dir[w], go CHECK; else stay.
REQ-019 CHECK: (dir_w=1 & m) or (dir_w=0 & z) -> EXEC; otherwise set blocked flag and go DONE.
REQ-020 EXEC: c_ld=1, op=~dir_w, then DONE.
REQ-021 DONE: ack[w]=1, err=blocked, update priority pointer, then IDLE.
REQ-022 op SHALL be 0 in every state except EXEC.
REQ-023 gnt[w]=1 in CHECK, EXEC and DONE; otherwise 0.
REQ-024 Latency: req sampled in IDLE at cycle T; ack at T+3 if executed, at T+2 if blocked.
REQ-025 req/dir changes after latch SHALL NOT affect the transaction in flight.
REQ-026 A req still high in the IDLE cycle after DONE SHALL be treated as a new request.
REQ-027 Both req bits set in IDLE: winner per REQ-033/034; the loser waits, with no request dropped.
REQ-028 At most one of c_ld, c_clr SHALL be high in any cycle.
REQ-029 Status z and m SHALL be used only in CHECK; no wrap-around is ever commanded.

Reset
REQ-030 Reset asserted SHALL force the following regardless of current state, including mid-transaction:
- state=INIT
- priority pointer=0
- latched w, dir_w and blocked flag cleared
- no ack is issued for an aborted transaction
REQ-031 Output values during reset SHALL be:
- c_clr=1
- op, c_ld, gnt, ack, err = 0
- busy=1
REQ-032 First cycle after reset release SHALL be INIT with c_clr=1, then IDLE.

Configuration
REQ-033 Macro RR_PRIORITY_EN defined: round-robin; pointer names the preferred requester and moves to ~w in DONE.
REQ-034 Macro RR_PRIORITY_EN undefined: fixed priority; requester 0 always wins ties, and the pointer register is omitted.

Structure
REQ-035 Shared package counter_ctrl_pkg SHALL hold the state encoding, the OP_INC=0 and OP_DEC=1 constants, and the requester count constant (2).
REQ-036 Winner selection SHALL be a sub-module rr_select (req, pointer -> w, valid).

Verification
REQ-037 Reset release -> c_clr=1 for one cycle, then busy=0, gnt=00.
REQ-038 req=01, dir=01, m=1 -> c_ld=1 with op=0 at T+2, ack=01 with err=0 at T+3.
REQ-039 req=10, dir=00, z=0 -> no c_ld, ack=10 with err=1 at T+2.
REQ-040 req=11 held continuously, RR_PRIORITY_EN defined -> acks alternate 01, 10, 01; undefined -> ack=01 only.
REQ-041 clr=1 and req=01 together in IDLE -> INIT (c_clr=1), then request served.
REQ-042 Reset pulse asserted in EXEC -> outputs per REQ-031 immediately, no ack, INIT after release.
